// File: rtl/conv_pkg.sv
// Shared widths and bank-state encoding for the conv-engine row buffers.
package conv_pkg;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;
    localparam int REP_W  = 4;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // A replay count of zero still means the row is sent once.
    function automatic logic [REP_W-1:0] rep_clamp(input logic [REP_W-1:0] rep);
        return (rep == '0) ? REP_W'(1) : rep;
    endfunction
endpackage

// File: rtl/reuse_line_buffer_ram.sv
// Simple dual-port RAM holding both row banks; address MSB selects the bank.
module reuse_sdp_ram
    import conv_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int AW = ADDR_W + 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/reuse_line_buffer.sv
// Ping-pong row buffer: one bank captures a row while the other replays its row
// several times into a 2-entry output FIFO.
module reuse_line_buffer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W:0]   cfg_row_len,
    input  logic [REP_W-1:0]  cfg_replay,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              m_pass_last,
    output logic [1:0]        bank_full,
    output logic              err_len
);
    logic clear;
    assign clear = !rst_n || flush;

    bank_state_t       bank_state_reg [2], bank_state_next [2];
    logic [ADDR_W:0]   len_b_reg [2], len_b_next [2];
    logic [REP_W-1:0]  rep_b_reg [2], rep_b_next [2];
    logic              wr_bank_reg, wr_bank_next, rd_bank_reg, rd_bank_next;
    logic [ADDR_W-1:0] wcnt_reg, wcnt_next, rcnt_reg, rcnt_next;
    logic [ADDR_W:0]   row_len_reg, row_len_next;
    logic [REP_W-1:0]  pass_reg, pass_next;
    logic              err_len_reg, err_len_next;
    logic              rd_valid_reg, rd_last_reg, rd_pass_last_reg;
    logic [DATA_W-1:0] fifo_data_reg [2];
    logic [1:0]        fifo_side_reg [2];
    logic              fifo_wptr_reg, fifo_rptr_reg;
    logic [1:0]        fifo_cnt_reg;
    logic [DATA_W-1:0] ram_rd_data;

    // Write-side decode
    logic            s_fire, at_len;
    logic [ADDR_W:0] cur_len;
    assign s_fire  = s_valid && s_ready;
    assign cur_len = (wcnt_reg == '0) ? cfg_row_len : row_len_reg;
    assign at_len  = ({1'b0, wcnt_reg} == cur_len - (ADDR_W+1)'(1));

    // Read-side decode; credit counts the pop of this cycle so the FIFO streams at 1 word/clk
    logic       fifo_pop, rd_issue, rd_word_last, rd_pass_last;
    logic [1:0] credit;
    assign fifo_pop     = m_valid && m_ready;
    assign credit       = fifo_cnt_reg + {1'b0, rd_valid_reg};
    assign rd_issue     = (bank_state_reg[rd_bank_reg] == DRAINING) &&
                          (credit < (fifo_pop ? 2'd3 : 2'd2));
    assign rd_word_last = ({1'b0, rcnt_reg} == len_b_reg[rd_bank_reg] - (ADDR_W+1)'(1));
    assign rd_pass_last = rd_word_last && (pass_reg == rep_b_reg[rd_bank_reg] - REP_W'(1));

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= EMPTY;
                len_b_reg[b]      <= '0;
                rep_b_reg[b]      <= '0;
            end
            wr_bank_reg      <= 1'b0;
            rd_bank_reg      <= 1'b0;
            wcnt_reg         <= '0;
            rcnt_reg         <= '0;
            row_len_reg      <= '0;
            pass_reg         <= '0;
            err_len_reg      <= 1'b0;
            rd_valid_reg     <= 1'b0;
            rd_last_reg      <= 1'b0;
            rd_pass_last_reg <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= bank_state_next[b];
                len_b_reg[b]      <= len_b_next[b];
                rep_b_reg[b]      <= rep_b_next[b];
            end
            wr_bank_reg      <= wr_bank_next;
            rd_bank_reg      <= rd_bank_next;
            wcnt_reg         <= wcnt_next;
            rcnt_reg         <= rcnt_next;
            row_len_reg      <= row_len_next;
            pass_reg         <= pass_next;
            err_len_reg      <= err_len_next;
            rd_valid_reg     <= rd_issue;
            rd_last_reg      <= rd_word_last;
            rd_pass_last_reg <= rd_pass_last;
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_next[b] = bank_state_reg[b];
            len_b_next[b]      = len_b_reg[b];
            rep_b_next[b]      = rep_b_reg[b];
        end
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        wcnt_next    = wcnt_reg;
        rcnt_next    = rcnt_reg;
        row_len_next = row_len_reg;
        pass_next    = pass_reg;
        err_len_next = 1'b0;

        if (s_fire) begin
            err_len_next = s_last ^ at_len;
            if (wcnt_reg == '0)
                row_len_next = cfg_row_len;
            if (s_last || at_len) begin
                bank_state_next[wr_bank_reg] = FULL;
                len_b_next[wr_bank_reg]      = {1'b0, wcnt_reg} + (ADDR_W+1)'(1);
                rep_b_next[wr_bank_reg]      = rep_clamp(cfg_replay);
                wr_bank_next                 = !wr_bank_reg;
                wcnt_next                    = '0;
            end else begin
                bank_state_next[wr_bank_reg] = FILLING;
                wcnt_next                    = wcnt_reg + ADDR_W'(1);
            end
        end

        // Writer only touches EMPTY/FILLING banks and reader only FULL/DRAINING, so no overlap
        if (bank_state_reg[rd_bank_reg] == FULL) begin
            bank_state_next[rd_bank_reg] = DRAINING;
        end else if (rd_issue) begin
            if (rd_word_last) begin
                rcnt_next = '0;
                if (rd_pass_last) begin
                    pass_next                    = '0;
                    bank_state_next[rd_bank_reg] = EMPTY;
                    rd_bank_next                 = !rd_bank_reg;
                    // Claim a waiting row immediately so the output has no bubble at bank swap
                    if (bank_state_reg[!rd_bank_reg] == FULL)
                        bank_state_next[!rd_bank_reg] = DRAINING;
                end else begin
                    pass_next = pass_reg + REP_W'(1);
                end
            end else begin
                rcnt_next = rcnt_reg + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            fifo_wptr_reg <= 1'b0;
            fifo_rptr_reg <= 1'b0;
            fifo_cnt_reg  <= '0;
        end else begin
            if (rd_valid_reg) begin
                fifo_data_reg[fifo_wptr_reg] <= ram_rd_data;
                fifo_side_reg[fifo_wptr_reg] <= {rd_pass_last_reg, rd_last_reg};
                fifo_wptr_reg                <= !fifo_wptr_reg;
            end
            if (fifo_pop)
                fifo_rptr_reg <= !fifo_rptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, rd_valid_reg} - {1'b0, fifo_pop};
        end
    end

    always_comb begin
        s_ready     = (bank_state_reg[wr_bank_reg] == EMPTY) ||
                      (bank_state_reg[wr_bank_reg] == FILLING);
        m_valid     = (fifo_cnt_reg != '0);
        m_data      = fifo_data_reg[fifo_rptr_reg];
        m_last      = m_valid && fifo_side_reg[fifo_rptr_reg][0];
        m_pass_last = m_valid && fifo_side_reg[fifo_rptr_reg][1];
        err_len     = err_len_reg;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank_full
        assign bank_full[gi] = (bank_state_reg[gi] == FULL) || (bank_state_reg[gi] == DRAINING);
    end

    reuse_sdp_ram #(
        .W  (DATA_W),
        .AW (ADDR_W + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (s_fire),
        .wr_addr ({wr_bank_reg, wcnt_reg}),
        .wr_data (s_data),
        .rd_en   (rd_issue),
        .rd_addr ({rd_bank_reg, rcnt_reg}),
        .rd_data (ram_rd_data)
    );
endmodule
